fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Burst round-robin arbiter sharing the 8-bit write port of the gray-pointer async FIFO between N_REQ write-side requesters. It lives entirely in the write clock domain. It drives wreqa/wdata into the FIFO and respects fulla back-pressure. Each grant is held for up to BURST_MAX beats so requesters get contiguous runs in the FIFO.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, data width, matches FIFO wdata
- BURST_MAX, 4, max beats per grant (1..16)
- clka  in  1  write-domain clock; single clock
- rstna  in  1  reset, synchronous, active-low
- req_vld  in  N_REQ  per-requester data valid
- req_data  in  N_REQ*DW  requester i data at bits [i*DW +: DW]
- req_rdy  out  N_REQ  per-requester accept; beat = req_vld[i] & req_rdy[i]
- wreqa  out  1  FIFO write strobe
- wdata  out  DW  FIFO write data
- fulla  in  1  FIFO full, write domain
- gnt_vld  out  1  a grant is active
- gnt_id  out  $clog2(N_REQ)  granted requester index, valid while gnt_vld
- stat_beats  out  N_REQ*16  per-requester beat counters (see Configuration)

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any req_vld, the pick is the first set bit scanning ptr+1, ptr+2, … modulo N_REQ. Register gnt_id, clear beat_cnt, go to GRANT. Otherwise stay.
- GRANT: req_rdy[gnt_id] = !fulla; all other req_rdy are 0.
  - wreqa = req_vld[gnt_id] & !fulla.
  - wdata = req_data[gnt_id], muxed combinationally.
  - A beat increments beat_cnt.
- Release from GRANT to IDLE, with ptr <= gnt_id, on either condition:
  - a beat with beat_cnt == BURST_MAX-1;
  - req_vld[gnt_id] low while !fulla (the requester went idle).
- Stall: fulla high holds GRANT and beat_cnt unchanged. A full FIFO never releases a grant. req_vld low while fulla is high does not release.
- A requester must hold req_data stable while req_vld is high and req_rdy is low.
- Arithmetic: beat_cnt is $clog2(BURST_MAX+1) bits. ptr wraps N_REQ-1 → 0.
- Reset (rstna low at an edge):
  - state IDLE, ptr = N_REQ-1 so requester 0 wins first, gnt_id 0, beat_cnt 0, stat counters 0.
  - Combinational outputs are forced low while rstna is low: req_rdy 0, wreqa 0, gnt_vld 0, wdata 0.
  - Reset mid-burst drops the grant with no further beat. The FIFO write side is reset by the same rstna.

## Timing
- Request to first beat: 1 cycle. req_vld seen in IDLE at edge k gives a grant at edge k+1, and the first beat is possible in cycle k+1.
- Throughput: 1 beat/cycle inside a grant.
- There is one IDLE bubble cycle between consecutive grants, including a re-grant to the same requester.
- fulla is used combinationally in the same cycle. No beat is issued in a cycle where fulla is high.
- All outputs are 0 out of reset.

## Configuration
- FIFO_WR_ARB_STATS_EN defined:
  - stat_beats[i*16 +: 16] counts beats accepted from requester i.
  - The counters saturate at 16'hFFFF and are cleared by reset.
- Not defined: the counter logic is absent and stat_beats is tied to 0. The port list is unchanged.

## Structure
- Package fifo_wr_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - DW default 8;
  - STAT_W = 16.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: any, idx.
  - Instantiated once.

## Test plan
- Reset, then only req_vld[2] with data 8'hA0..A3 and fulla 0 → gnt_id 2 one cycle after request; 4 consecutive wreqa cycles with wdata A0..A3; gnt_vld drops.
- All 4 requesters valid continuously, BURST_MAX 4 → grant order 0,1,2,3,0. Each grant is 4 beats followed by 1 bubble cycle.
- Requester 1 granted; fulla rises after beat 2 for 5 cycles → wreqa 0 and grant held for those 5 cycles; beats 3 and 4 follow when fulla falls; no extra beat is counted.
- Requester 0 drops req_vld after 2 beats with requester 3 pending → release; 1 bubble; gnt_id 3; ptr now 0, so a new req 1 beats req 3 on the next arbitration.
- rstna low mid-burst (beat 2 of requester 2) → next edge gives gnt_vld 0, wreqa 0, and requester 0 is granted first after release.
- With FIFO_WR_ARB_STATS_EN, 10 beats from requester 1 → stat_beats[31:16] = 10. Without the macro → stat_beats stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared types and constants for the FIFO write-port arbiter:
//   state_t     - arbiter FSM state (IDLE, GRANT)
//   DW_DEFAULT  - default data width, matches the async FIFO wdata
//   STAT_W      - width of each per-requester beat counter
// ---------------------------------------------------------------------------
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DW_DEFAULT = 8;
   localparam int STAT_W     = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshake, the FIFO write port and the grant/status
// outputs of fifo_wr_arbiter.
//   req_vld/req_data/req_rdy - N_REQ requester handshakes, data at [i*DW +: DW]
//   wreqa/wdata/fulla        - FIFO write strobe, data and full flag
//   gnt_vld/gnt_id           - active grant and its owner
//   stat_beats               - per-requester beat counters, STAT_W bits each
// slave modport: arbiter side.  master modport: requesters/FIFO side.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int DW    = fifo_wr_arb_pkg::DW_DEFAULT
) ();

   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]                        req_vld;
   logic [N_REQ*DW-1:0]                     req_data;
   logic [N_REQ-1:0]                        req_rdy;
   logic                                    wreqa;
   logic [DW-1:0]                           wdata;
   logic                                    fulla;
   logic                                    gnt_vld;
   logic [ID_W-1:0]                         gnt_id;
   logic [N_REQ*fifo_wr_arb_pkg::STAT_W-1:0] stat_beats;

   modport slave (
      input  req_vld, req_data, fulla,
      output req_rdy, wreqa, wdata, gnt_vld, gnt_id, stat_beats
   );

   modport master (
      output req_vld, req_data, fulla,
      input  req_rdy, wreqa, wdata, gnt_vld, gnt_id, stat_beats
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Scans ptr+1, ptr+2, ... modulo N_REQ
// and returns the first set request bit.
//   req  in  N_REQ  request vector
//   ptr  in  ID_W   last served index (lowest priority)
//   any  out 1      at least one request set
//   idx  out ID_W   winning index, 0 when any is low
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] j;

   // Walk from the lowest priority to the highest so the nearest
   // candidate after ptr is the last one written.
   always_comb begin
      any = 1'b0;
      idx = '0;
      j   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = ID_W'((int'(ptr) + k) % N_REQ);
         if (req[j]) begin
            any = 1'b1;
            idx = j;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Burst round-robin arbiter sharing the async FIFO write port between N_REQ
// requesters, write clock domain only. A grant lasts up to BURST_MAX beats,
// or until the owner drops req_vld while the FIFO is not full. A full FIFO
// stalls the grant without releasing it. One IDLE cycle separates grants.
//   clka   in  write-domain clock
//   rstna  in  synchronous active-low reset; also forces all outputs low
//   bus    slave modport of fifo_wr_arbiter_if (requesters, FIFO, status)
// Optional: define FIFO_WR_ARB_STATS_EN to enable the saturating
// per-requester beat counters on stat_beats; otherwise stat_beats is 0.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = DW_DEFAULT,
   parameter int BURST_MAX = 4
) (
   input  logic             clka,
   input  logic             rstna,
   fifo_wr_arbiter_if.slave bus
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gnt_id_q;
   logic [CNT_W-1:0] beat_cnt;

   logic            pick_any;
   logic [ID_W-1:0] pick_idx;
   logic            sel_vld;
   logic            in_grant;
   logic            beat;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req (bus.req_vld),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign in_grant = rstna && (state == GRANT);
   assign sel_vld  = bus.req_vld[gnt_id_q];
   assign beat     = in_grant && sel_vld && !bus.fulla;

   always_ff @(posedge clka) begin
      if (!rstna) begin
         state    <= IDLE;
         ptr      <= ID_W'(N_REQ - 1);
         gnt_id_q <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_id_q <= pick_idx;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // fulla freezes everything, including an idle owner.
               if (!bus.fulla) begin
                  if (!sel_vld || (beat_cnt == CNT_W'(BURST_MAX - 1))) begin
                     state <= IDLE;
                     ptr   <= gnt_id_q;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.req_rdy = '0;
      if (in_grant && !bus.fulla) bus.req_rdy[gnt_id_q] = 1'b1;
   end

   assign bus.wreqa   = beat;
   assign bus.gnt_vld = in_grant;
   assign bus.gnt_id  = rstna ? gnt_id_q : '0;
   assign bus.wdata   = rstna ? bus.req_data[int'(gnt_id_q)*DW +: DW] : '0;

`ifdef FIFO_WR_ARB_STATS_EN
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

   logic [STAT_W-1:0] stat_q [N_REQ];

   always_ff @(posedge clka) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (!rstna) begin
            stat_q[i] <= '0;
         end else if (beat && (gnt_id_q == ID_W'(i))) begin
            stat_q[i] <= sat_inc(stat_q[i]);
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      assign bus.stat_beats[g*STAT_W +: STAT_W] = stat_q[g];
   end
`else
   assign bus.stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. Each requester owns a queue of
// pending data; a transaction-level model tracks the current grant owner,
// beats taken and the last served requester, and predicts every output.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BM = 4;
   localparam int SW = 16;

   logic clka = 1'b0;
   logic rstna;

   always #5 clka = ~clka;

   fifo_wr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DW        (DW),
      .BURST_MAX (BM)
   ) dut (
      .clka  (clka),
      .rstna (rstna),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // stimulus state
   logic [DW-1:0] strm [N][$];
   bit            en [N];
   bit            fulla_drv;
   bit            rst_drv;

   // reference model
   bit m_act;
   int m_own;
   int m_beats;
   int m_last;
   int m_stat [N];

   // observation logs
   int            glog [$];
   logic [DW-1:0] wlog [$];
   bit            prev_gv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic step();
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      logic [N-1:0]    erdy;
      bit              ewr;
      bit              found;
      int              ex;
      @(negedge clka);
      for (int i = 0; i < N; i++) begin
         v[i] = en[i] && (strm[i].size() > 0);
         d[i*DW +: DW] = v[i] ? strm[i][0] : '0;
      end
      rstna        = rst_drv;
      bus.req_vld  = v;
      bus.req_data = d;
      bus.fulla    = fulla_drv;
      #1;
      erdy = '0;
      ewr  = 0;
      if (rstna && m_act && !fulla_drv) begin
         erdy[m_own] = 1'b1;
         ewr = v[m_own];
      end
      chk("gnt_vld", 32'(bus.gnt_vld), 32'(rstna && m_act));
      if (rstna && m_act) chk("gnt_id", 32'(bus.gnt_id), 32'(m_own));
      chk("req_rdy", 32'(bus.req_rdy), 32'(erdy));
      chk("wreqa", 32'(bus.wreqa), 32'(ewr));
      if (ewr) chk("wdata", 32'(bus.wdata), 32'(strm[m_own][0]));
      else if (!rstna) chk("wdata_rst", 32'(bus.wdata), 32'd0);
      for (int i = 0; i < N; i++) begin
`ifdef FIFO_WR_ARB_STATS_EN
         ex = m_stat[i];
`else
         ex = 0;
`endif
         chk("stat_beats", 32'(bus.stat_beats[i*SW +: SW]), 32'(ex));
      end
      if (bus.gnt_vld && !prev_gv) glog.push_back(int'(bus.gnt_id));
      prev_gv = bus.gnt_vld;
      if (bus.wreqa) wlog.push_back(bus.wdata);

      // advance the model across the coming edge
      if (!rstna) begin
         m_act   = 0;
         m_last  = N - 1;
         m_beats = 0;
         foreach (m_stat[i]) m_stat[i] = 0;
      end else if (!m_act) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && v[(m_last + k) % N]) begin
               found   = 1;
               m_own   = (m_last + k) % N;
               m_act   = 1;
               m_beats = 0;
            end
         end
      end else if (!fulla_drv) begin
         if (v[m_own]) begin
            void'(strm[m_own].pop_front());
            m_beats++;
            if (m_stat[m_own] < 65535) m_stat[m_own]++;
            if (m_beats == BM) begin
               m_act  = 0;
               m_last = m_own;
            end
         end else begin
            m_act  = 0;
            m_last = m_own;
         end
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) begin
         strm[i].delete();
         en[i] = 0;
      end
      fulla_drv = 0;
      rst_drv   = 0;
      step();
      step();
      rst_drv = 1;
      step();
      glog.delete();
      wlog.delete();
   endtask

   initial begin
      rstna     = 1'b0;
      rst_drv   = 0;
      fulla_drv = 0;
      prev_gv   = 0;
      m_act     = 0;
      m_own     = 0;
      m_beats   = 0;
      m_last    = N - 1;
      foreach (m_stat[i]) m_stat[i] = 0;
      foreach (en[i]) en[i] = 0;
      bus.req_vld  = '0;
      bus.req_data = '0;
      bus.fulla    = 1'b0;

      // single requester burst
      do_reset();
      for (int k = 0; k < 4; k++) strm[2].push_back(DW'(8'hA0 + k));
      en[2] = 1;
      for (int c = 0; c < 8; c++) step();
      chk("t1_grants", 32'(glog.size()), 32'd1);
      if (glog.size() > 0) chk("t1_gnt_id", 32'(glog[0]), 32'd2);
      chk("t1_beats", 32'(wlog.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (wlog.size() > k) chk("t1_wdata", 32'(wlog[k]), 32'(8'hA0 + k));

      // all requesters busy: round-robin order
      do_reset();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 8; k++) strm[i].push_back(DW'(i * 16 + k));
         en[i] = 1;
      end
      for (int c = 0; c < 26; c++) step();
      chk("t2_grants", 32'(glog.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++)
         if (glog.size() > k) chk("t2_order", 32'(glog[k]), 32'(k % N));

      // fulla stall in the middle of a burst
      do_reset();
      for (int k = 0; k < 4; k++) strm[1].push_back(DW'(8'h10 + k));
      en[1] = 1;
      for (int c = 0; c < 12; c++) begin
         fulla_drv = (c >= 3) && (c <= 7);
         step();
      end
      fulla_drv = 0;
      chk("t3_beats", 32'(wlog.size()), 32'd4);
      chk("t3_grants", 32'(glog.size()), 32'd1);

      // early release when the owner goes idle
      do_reset();
      strm[0].push_back(8'h01);
      strm[0].push_back(8'h02);
      for (int k = 0; k < 4; k++) strm[3].push_back(DW'(8'h30 + k));
      en[0] = 1;
      en[3] = 1;
      for (int c = 0; c < 12; c++) step();
      chk("t4_grants", 32'(glog.size()), 32'd2);
      if (glog.size() > 1) begin
         chk("t4_first", 32'(glog[0]), 32'd0);
         chk("t4_second", 32'(glog[1]), 32'd3);
      end

      // reset in the middle of a burst
      do_reset();
      for (int k = 0; k < 6; k++) strm[2].push_back(DW'(8'h20 + k));
      en[2] = 1;
      for (int c = 0; c < 3; c++) step();
      rst_drv = 0;
      for (int k = 0; k < 2; k++) strm[0].push_back(DW'(8'h50 + k));
      en[0] = 1;
      step();
      rst_drv = 1;
      for (int c = 0; c < 6; c++) step();
      chk("t5_beats_before", 32'(wlog.size() >= 2), 32'd1);
      if (glog.size() > 1) chk("t5_after_rst", 32'(glog[1]), 32'd0);
      else chk("t5_grants", 32'(glog.size()), 32'd2);

      // beat counter over 10 beats from requester 1
      do_reset();
      for (int k = 0; k < 10; k++) strm[1].push_back(DW'(k));
      en[1] = 1;
      for (int c = 0; c < 18; c++) step();
`ifdef FIFO_WR_ARB_STATS_EN
      chk("t6_stat1", 32'(bus.stat_beats[31:16]), 32'd10);
`else
      chk("t6_stat1", 32'(bus.stat_beats[31:16]), 32'd0);
`endif

      // randomized traffic with back-pressure and occasional reset
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         fulla_drv = ($urandom_range(0, 4) == 0);
         rst_drv   = ($urandom_range(0, 399) != 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) en[i] = !en[i];
            if ((strm[i].size() < 3) && ($urandom_range(0, 2) == 0))
               strm[i].push_back(DW'($urandom));
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
